// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Generates sequential PCs and drives a synchronous IMEM with 1-cycle read latency.
// Buffers {pc, instr} pairs in a prefetch FIFO and presents them to decode
// over a valid/ready handshake. A redirect discards wrong-path data.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     IMEM_AW  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_en,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_resp_pending;
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [XLEN-1:0] r_fifo_instr [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [CW:0]     w_inflight;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_tgt;

    // Credit counts the entry already in flight; a same-cycle pop is ignored,
    // so a push can never land in a full FIFO.
    assign w_inflight     = {1'b0, r_count} + {{CW{1'b0}}, r_resp_pending};
    assign w_issue        = !rst && !redirect_valid && (w_inflight < DEPTH_W);
    assign w_push         = !rst && !redirect_valid && r_resp_pending;
    assign w_pop          = out_valid && out_ready;
    assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

    assign imem_en   = w_issue;
    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign out_valid = !rst && (r_count != '0);
    assign out_pc    = r_fifo_pc[r_rd_ptr];
    assign out_instr = r_fifo_instr[r_rd_ptr];
    assign occupancy = r_count;

    // PC, request tracking and FIFO pointer/count control; reset beats redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_req_pc       <= '0;
            r_resp_pending <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else if (redirect_valid) begin
            r_pc           <= w_redirect_tgt;
            r_resp_pending <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else begin
            r_resp_pending <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + XLEN'(4);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the returning instruction with its request PC
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    // Guard the credit rule: a push must never target a full FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && (r_count == FULL_CNT)))
                else $error("fetch_unit: push into full fifo");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a
// PC-stream scoreboard (expected PCs queued, popped on each handshake).
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    logic [31:0] imem [1024];
    logic [31:0] exp_q [$];
    logic [31:0] exp_next;
    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH),
        .IMEM_AW(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous IMEM model, one-cycle read latency
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, got, exp);
            end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h0000_03FF);
    endfunction

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] start);
        exp_q.delete();
        exp_next = start;
        refill();
    endtask

    // Scoreboard: compare every consumed head against the expected PC stream
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            model_restart(RESET_PC);
        end else begin
            if (out_valid && out_ready) begin
                refill();
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e);
                chk("pop_instr", out_instr, instr_of(e));
                pop_cnt++;
                refill();
            end
            if (redirect_valid) model_restart(redirect_pc & 32'hFFFF_FFFC);
        end
        chk("occ_bound", (occupancy <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) cyc();
        smp();
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_occ", {29'b0, occupancy}, 32'd0);

        // Reset release: issue at once, first output two cycles later
        cyc(); rst = 1'b0;
        smp();
        chk("rel_imem_en", {31'b0, imem_en}, 32'd1);
        chk("rel_imem_addr", {22'b0, imem_addr}, 32'd0);
        cyc(); smp();
        chk("rel_valid_r1", {31'b0, out_valid}, 32'd0);
        cyc(); smp();
        chk("rel_valid_r2", {31'b0, out_valid}, 32'd1);
        chk("rel_pc_r2", out_pc, 32'h0);
        chk("rel_instr_r2", out_instr, 32'h1000_0000);
        for (int i = 0; i < 8; i++) begin
            cyc(); smp();
            chk("stream_no_gap", {31'b0, out_valid}, 32'd1);
        end

        // Backpressure from a fresh start
        cyc(); rst = 1'b1; out_ready = 1'b0;
        cyc(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (i >= 2) begin
                chk("bp_valid", {31'b0, out_valid}, 32'd1);
                chk("bp_head_pc", out_pc, 32'h0);
            end
            if (i >= 5) begin
                chk("bp_occ_full", {29'b0, occupancy}, 32'd4);
                chk("bp_no_issue", {31'b0, imem_en}, 32'd0);
            end
            cyc();
        end
        out_ready = 1'b1;
        repeat (8) cyc();

        // Redirect with a response in flight
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        smp();
        chk("redir_no_issue", {31'b0, imem_en}, 32'd0);
        cyc(); redirect_valid = 1'b0;
        smp();
        chk("redir_t1_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_t1_occ", {29'b0, occupancy}, 32'd0);
        cyc(); smp();
        chk("redir_t2_valid", {31'b0, out_valid}, 32'd0);
        cyc(); smp();
        chk("redir_t3_valid", {31'b0, out_valid}, 32'd1);
        chk("redir_t3_pc", out_pc, 32'h40);
        cyc(); smp();
        chk("redir_t4_pc", out_pc, 32'h44);

        // Redirect and pop in the same cycle, unaligned target
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        smp();
        chk("rp_pop_valid", {31'b0, out_valid}, 32'd1);
        cyc(); redirect_valid = 1'b0;
        cyc(); cyc(); smp();
        chk("rp_masked_pc", out_pc, 32'h100);

        // PC wraps modulo 2^32
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc(); redirect_valid = 1'b0;
        cyc(); cyc(); smp();
        chk("wrap_t3_pc", out_pc, 32'hFFFF_FFF8);
        cyc(); cyc(); smp();
        chk("wrap_t5_pc", out_pc, 32'h0);
        chk("wrap_t5_instr", out_instr, 32'h1000_0000);

        // Back-to-back redirects: last one wins
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc(); redirect_pc = 32'h300;
        cyc(); redirect_valid = 1'b0;
        cyc(); cyc(); smp();
        chk("b2b_pc", out_pc, 32'h300);

        // Reset has priority over redirect
        cyc(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        cyc(); rst = 1'b0; redirect_valid = 1'b0;
        smp();
        chk("prio_addr", {22'b0, imem_addr}, 32'd0);
        cyc(); cyc(); smp();
        chk("prio_pc", out_pc, RESET_PC);

        // Reset mid-stream with occupancy 3 and a response pending
        cyc(); rst = 1'b1; out_ready = 1'b0;
        cyc(); rst = 1'b0;
        cyc(); cyc(); cyc();
        smp();
        chk("mid_occ2", {29'b0, occupancy}, 32'd2);
        chk("mid_issue", {31'b0, imem_en}, 32'd1);
        cyc(); rst = 1'b1;
        smp();
        chk("mid_occ3", {29'b0, occupancy}, 32'd3);
        cyc(); rst = 1'b0; out_ready = 1'b1;
        smp();
        chk("mid_valid_after", {31'b0, out_valid}, 32'd0);
        chk("mid_occ_after", {29'b0, occupancy}, 32'd0);
        cyc(); cyc(); smp();
        chk("mid_first_valid", {31'b0, out_valid}, 32'd1);
        chk("mid_first_pc", out_pc, RESET_PC);

        // Random backpressure and redirects
        pop_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 49) == 0);
            redirect_pc = $urandom_range(0, 32'h1FFF);
        end
        cyc(); redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (10) cyc();
        smp();
        chk("rand_progress", (pop_cnt > 2000) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the bare PC + IMEM coupling.
- Generates sequential PCs and drives the synchronous instruction BRAM (1-cycle read latency).
- Buffers {pc, instr} pairs in a DEPTH-entry prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/flush) with discard of wrong-path data, and stalls from decode without losing or duplicating instructions.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, prefetch FIFO entries; power of 2, ≥2.
- IMEM_AW, 10, IMEM word-address width; imem_addr = pc[IMEM_AW+1:2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0.
- imem_en  out  1  IMEM read enable.
- imem_addr  out  IMEM_AW  IMEM word address.
- imem_rdata  in  XLEN  IMEM data, valid the cycle after imem_en.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  PC of head.
- out_instr  out  XLEN  instruction of head.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (rst=1 at edge):
  - pc_q=RESET_PC; FIFO emptied; occupancy=0; resp_pending=0.
  - imem_en=0 and out_valid=0 while rst is high.
  - out_pc and out_instr are don't-care while out_valid=0.
- Issue:
  - Condition: !rst && !redirect_valid && (occupancy + resp_pending) < DEPTH.
  - Credit is computed conservatively; a same-cycle pop is not counted.
  - On issue: imem_en=1, imem_addr=pc_q[IMEM_AW+1:2], req_pc_q<=pc_q, pc_q<=pc_q+4, resp_pending<=1.
  - Otherwise: resp_pending<=0; pc_q holds.
- Response: when resp_pending=1 and no redirect, {req_pc_q, imem_rdata} is pushed at that cycle's edge.
- Latency: issue in cycle N → push at end of N+1 → out_valid in N+2. Back-to-back issue sustains 1 instr/cycle with out_ready=1.
- Handshake:
  - Pop when out_valid && out_ready.
  - out_valid, out_pc and out_instr stay stable until popped.
  - Push and pop in the same cycle leave occupancy unchanged.
- Overflow: the credit rule guarantees no push ever occurs into a full FIFO; assertion-checked.
- Redirect (redirect_valid=1 in cycle T):
  - FIFO cleared and occupancy=0 at end of T; out_valid=0 in T+1.
  - Any pending response (issued T-1) is discarded.
  - No issue in T; pc_q<= {redirect_pc[XLEN-1:2],2'b00}.
  - Issue of the target in T+1; target at head with out_valid=1 in T+3.
  - A pop in cycle T is still a valid consumption by decode; head is then discarded with the rest.
- Back-to-back redirects: the last one wins; each clears state again.
- Reset vs redirect: rst has priority over redirect_valid.
- Reset mid-stream: everything is flushed as above; restart from RESET_PC; no stale entry appears.
- PC wrap: pc_q+4 wraps modulo 2^XLEN; imem_addr wraps modulo 2^IMEM_AW.
- Occupancy counts 0..DEPTH; read/write pointers use log2(DEPTH) bits with natural wrap.

Test Plan:
- Reset release, IMEM preloaded word[i]=32'h1000_0000+i, out_ready=1:
  - imem_en high in first cycle after rst falls.
  - out_valid two cycles later with out_pc=0, out_instr=32'h1000_0000.
  - Continues pc=4,8,… one per cycle with no gaps or duplicates.
- Backpressure, out_ready=0 for 10 cycles, DEPTH=4:
  - occupancy reaches 4; imem_en then stays 0.
  - Head stays pc=0 throughout.
  - On release, pops pc=0,4,8,12,16… in order.
- Redirect with in-flight response, redirect_pc=0x40 at cycle T while streaming:
  - FIFO empty at T+1; the response issued at T-1 is never output.
  - out_pc=0x40 valid at T+3, followed by 0x44.
- Redirect and pop same cycle, redirect_pc=0x103 with out_ready=1:
  - Popped head is consumed once.
  - Next out_pc=0x100, confirming bits [1:0] are masked.
- Reset asserted mid-stream with occupancy=3 and resp_pending=1:
  - out_valid=0 the following cycle.
  - After release, the first output is pc=RESET_PC.
- Random out_ready plus random redirects over 10k cycles against a reference model:
  - Output PC sequence matches the model exactly.
  - No overflow assertion fires.
  - occupancy never exceeds DEPTH.
